// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - shared state type and default sizing for the pulse scheduler
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int N_CH_DEF  = 4;
  localparam int GAP_W_DEF = 4;

endpackage

// File: rtl/pulse_sched_if.sv
// rtl/pulse_sched_if.sv - request/strobe bundle between requesters and the pulse scheduler
interface pulse_sched_if
  import pulse_sched_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int GAP_W = GAP_W_DEF
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              en;
  logic [GAP_W-1:0]  gap_cfg;
  logic [N_CH-1:0]   req_i;
  logic              pulse_o;
  logic [CH_W-1:0]   pulse_ch_o;
  logic [N_CH-1:0]   pending_o;
  logic              busy_o;
`ifdef PULSE_SCHED_OVF_EN
  logic              ovf_clr;
  logic [N_CH-1:0]   ovf_o;

  modport master (output en, gap_cfg, req_i, ovf_clr,
                  input  pulse_o, pulse_ch_o, pending_o, busy_o, ovf_o);
  modport slave  (input  en, gap_cfg, req_i, ovf_clr,
                  output pulse_o, pulse_ch_o, pending_o, busy_o, ovf_o);
`else
  modport master (output en, gap_cfg, req_i,
                  input  pulse_o, pulse_ch_o, pending_o, busy_o);
  modport slave  (input  en, gap_cfg, req_i,
                  output pulse_o, pulse_ch_o, pending_o, busy_o);
`endif

endinterface

// File: rtl/pulse_sched_rr.sv
// rtl/pulse_sched_rr.sv - combinational round-robin picker over the pending vector
module pulse_sched_rr #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] pending,
  input  logic [CH_W-1:0] ptr,
  output logic            valid,
  output logic [CH_W-1:0] grant
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   win;
  logic [CH_W:0]     sum;

  // Rotating a doubled copy puts ptr at bit 0, so the lowest set bit is the winner.
  always_comb begin
    dbl   = {pending, pending};
    win   = N_CH'(dbl >> ptr);
    valid = |pending;
    sum   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (win[j]) sum = {1'b0, ptr} + (CH_W + 1)'(j);
    end
    if (sum >= (CH_W + 1)'(N_CH)) grant = CH_W'(sum - (CH_W + 1)'(N_CH));
    else                           grant = sum[CH_W-1:0];
  end

endmodule

// File: rtl/pulse_sched.sv
// rtl/pulse_sched.sv - round-robin one-strobe pulse scheduler; PULSE_SCHED_OVF_EN adds sticky overflow flags
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input logic        clk,
  input logic        reset,
  pulse_sched_if.slave bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t            state, state_n;
  logic [N_CH-1:0]   req_q, rise, pending, grant_vec;
  logic [CH_W-1:0]   ptr, pulse_ch, rr_grant, ptr_n;
  logic              rr_valid, grant_en;
  logic [GAP_W-1:0]  cnt;

  pulse_sched_rr #(.N_CH(N_CH), .CH_W(CH_W)) u_rr (
    .pending (pending),
    .ptr     (ptr),
    .valid   (rr_valid),
    .grant   (rr_grant)
  );

  assign rise      = bus.req_i & ~req_q;
  assign grant_en  = (state == IDLE) && bus.en && rr_valid;
  assign grant_vec = grant_en ? (N_CH'(1) << rr_grant) : '0;
  assign ptr_n     = (rr_grant == CH_W'(N_CH - 1)) ? '0 : rr_grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_en) state_n = PULSE;
      PULSE:   state_n = (bus.gap_cfg == '0) ? IDLE : GAP;
      GAP:     if (cnt == GAP_W'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.pulse_o = (state == PULSE);
    bus.busy_o  = (state != IDLE);
  end

  // req_q resets high so a request held through reset does not count as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q    <= '1;
      pending  <= '0;
      ptr      <= '0;
      cnt      <= '0;
      pulse_ch <= '0;
    end else begin
      req_q   <= bus.req_i;
      pending <= (pending & ~grant_vec) | rise;
      if (grant_en) begin
        pulse_ch <= rr_grant;
        ptr      <= ptr_n;
      end
      if (state == PULSE)    cnt <= bus.gap_cfg;
      else if (state == GAP) cnt <= cnt - 1'b1;
    end
  end

  assign bus.pulse_ch_o = pulse_ch;
  assign bus.pending_o  = pending;

`ifdef PULSE_SCHED_OVF_EN
  logic [N_CH-1:0] ovf;

  always_ff @(posedge clk) begin
    if (reset) ovf <= '0;
    else       ovf <= (ovf & ~{N_CH{bus.ovf_clr}}) | (rise & pending & ~grant_vec);
  end

  assign bus.ovf_o = ovf;
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// tb/tb_pulse_sched.sv - scoreboard bench for pulse_sched with directed request patterns
module tb_pulse_sched;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  pulse_sched_if #(.N_CH(4), .GAP_W(4)) bus ();

  pulse_sched #(.N_CH(4), .GAP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.pulse_o === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got ch=%0d at cyc=%0d, required no pulse", bus.pulse_ch_o, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(bus.pulse_ch_o) != e.ch || cyc != e.cyc) begin
          fails++;
          $display("FAIL pulse: got ch=%0d cyc=%0d, required ch=%0d cyc=%0d", bus.pulse_ch_o, cyc, e.ch, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic expect_pulse(input int ch, input int at);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.req_i  = 4'b0000;
    step(2);
    reset      = 1'b0;
    step(1);
  endtask

  int k;

  initial begin
    reset       = 1'b1;
    bus.en      = 1'b1;
    bus.gap_cfg = 4'd0;
    bus.req_i   = 4'b0001;
`ifdef PULSE_SCHED_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    step(3);
    check("rst_pulse",   int'(bus.pulse_o), 0);
    check("rst_ch",      int'(bus.pulse_ch_o), 0);
    check("rst_pending", int'(bus.pending_o), 0);
    check("rst_busy",    int'(bus.busy_o), 0);
`ifdef PULSE_SCHED_OVF_EN
    check("rst_ovf",     int'(bus.ovf_o), 0);
`endif
    reset = 1'b0;
    step(4);
    check("held_req_no_edge", int'(bus.pending_o), 0);

    // drop and re-raise channel 0
    bus.req_i = 4'b0000;
    step(1);
    bus.req_i = 4'b0001;
    k = cyc;
    expect_pulse(0, k + 2);
    step(1);
    check("t1_pending", int'(bus.pending_o), 1);
    check("t1_busy_idle", int'(bus.busy_o), 0);
    step(1);
    check("t1_pending_clr", int'(bus.pending_o), 0);
    check("t1_ch", int'(bus.pulse_ch_o), 0);
    step(3);

    // all four rise together, gap 0
    do_reset();
    bus.req_i = 4'b1111;
    k = cyc;
    expect_pulse(0, k + 2);
    expect_pulse(1, k + 4);
    expect_pulse(2, k + 6);
    expect_pulse(3, k + 8);
    step(1);
    check("t2_pending", int'(bus.pending_o), 15);
    step(10);

    // gap 3 between channels 2 and 3
    bus.gap_cfg = 4'd3;
    bus.req_i   = 4'b0000;
    step(1);
    bus.req_i = 4'b1100;
    k = cyc;
    expect_pulse(2, k + 2);
    expect_pulse(3, k + 7);
    step(1);
    check("t3_pending", int'(bus.pending_o), 12);
    step(2);
    check("t3_busy_gap_a", int'(bus.busy_o), 1);
    check("t3_no_pulse_gap", int'(bus.pulse_o), 0);
    step(2);
    check("t3_busy_gap_b", int'(bus.busy_o), 1);
    step(8);
    check("t3_idle", int'(bus.busy_o), 0);

    // edges accumulate while en is low
    bus.gap_cfg = 4'd0;
    bus.en      = 1'b0;
    bus.req_i   = 4'b0000;
    step(1);
    bus.req_i = 4'b0110;
    step(3);
    check("t4_pending", int'(bus.pending_o), 6);
    check("t4_busy", int'(bus.busy_o), 0);
    bus.en = 1'b1;
    k = cyc;
    expect_pulse(1, k + 1);
    expect_pulse(2, k + 3);
    step(6);

    // channel 2 toggles twice before its grant
    bus.en    = 1'b0;
    bus.req_i = 4'b0000;
    step(1);
    bus.req_i = 4'b0100;
    step(1);
    bus.req_i = 4'b0000;
    step(1);
    bus.req_i = 4'b0100;
    step(1);
    check("t5_pending", int'(bus.pending_o), 4);
`ifdef PULSE_SCHED_OVF_EN
    check("t5_ovf_set", int'(bus.ovf_o), 4);
`endif
    bus.en = 1'b1;
    k = cyc;
    expect_pulse(2, k + 1);
    step(5);
    check("t5_pending_clr", int'(bus.pending_o), 0);
`ifdef PULSE_SCHED_OVF_EN
    check("t5_ovf_sticky", int'(bus.ovf_o), 4);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    check("t5_ovf_clr", int'(bus.ovf_o), 0);
`endif

    // reset lands during GAP with another edge pending
    bus.gap_cfg = 4'd5;
    bus.req_i   = 4'b0000;
    step(1);
    bus.req_i = 4'b0010;
    k = cyc;
    expect_pulse(1, k + 2);
    step(3);
    bus.req_i = 4'b1010;
    step(1);
    check("t6_busy_gap", int'(bus.busy_o), 1);
    check("t6_pending", int'(bus.pending_o), 8);
    check("t6_ch", int'(bus.pulse_ch_o), 1);
    reset = 1'b1;
    step(1);
    check("t6_rst_busy", int'(bus.busy_o), 0);
    check("t6_rst_pending", int'(bus.pending_o), 0);
    check("t6_rst_ch", int'(bus.pulse_ch_o), 0);
    reset     = 1'b0;
    bus.req_i = 4'b0000;
    step(8);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Round-robin pulse scheduler sharing one strobe line among N_CH requesters. Each requester raises a level request. The block detects each low-to-high transition and queues one pending pulse per channel. It then issues one-cycle pulses on a single shared output, tagged with the channel index, with a programmable minimum gap between pulses. It sits between the per-source request logic and the single downstream consumer of the pulse strobe.

## Interface
Parameters:
- N_CH, 4: number of requesting channels (2..16).
- GAP_W, 4: width of gap configuration.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  grant enable; when low, no new pulse is started.
- gap_cfg  in  GAP_W  idle cycles inserted after each pulse.
- req_i  in  N_CH  level requests, one bit per channel.
- pulse_o  out  1  one-cycle strobe.
- pulse_ch_o  out  $clog2(N_CH)  channel served by the current/last pulse.
- pending_o  out  N_CH  per-channel queued-edge flags.
- busy_o  out  1  high whenever state is not IDLE.
- ovf_clr  in  1  (PULSE_SCHED_OVF_EN only) clears ovf_o.
- ovf_o  out  N_CH  (PULSE_SCHED_OVF_EN only) sticky dropped-edge flags.

## Operation
- Edge detect:
  - req_q registers req_i. Reset value is all ones, so a request held high through reset yields no edge until it first drops low.
  - rise[i] = req_i[i] & ~req_q[i].
- Pending:
  - pending[i] is set on rise[i] and cleared when channel i is granted.
  - If rise and grant for the same channel occur in the same cycle, the set wins.
  - A second rise while pending is already set merges into the existing flag. Only one pulse is owed.
- Round-robin:
  - Pointer ptr resets to 0.
  - In IDLE, the grant goes to the first set pending bit searching from ptr upward, wrapping modulo N_CH.
  - On grant, ptr becomes (granted+1) mod N_CH.
- FSM states are IDLE, PULSE and GAP.
  - IDLE: if en and any pending bit is set, then grant, load pulse_ch_o, and go to PULSE. Otherwise stay in IDLE.
  - PULSE: pulse_o=1 for exactly this cycle. If gap_cfg==0, go to IDLE. Otherwise load cnt=gap_cfg (sampled here) and go to GAP.
  - GAP: decrement cnt. When cnt==1, go to IDLE.
- en low only blocks the IDLE→PULSE transition. An in-flight PULSE/GAP completes, and pending keeps accumulating.
- Outputs:
  - pulse_o = (state==PULSE).
  - busy_o = (state!=IDLE).
  - pulse_ch_o holds its value until the next grant.
- Reset mid-operation: the FSM returns to IDLE, and pending, ptr, cnt and pulse_ch_o are cleared. Any truncated pulse is not reissued.

## Timing
- Reset values:
  - pulse_o=0, pulse_ch_o=0, pending_o=0, busy_o=0, ovf_o=0.
  - req_q=all ones, state=IDLE.
- Latency: req_i sampled high at edge E0 (previously low) → pending_o[i]=1 after E0 → pulse_o=1 after E1, low after E2. pending_o[i] clears after E1.
- Pulse spacing: back-to-back pulses start gap_cfg+2 cycles apart (2 cycles when gap_cfg=0).
- gap_cfg is sampled only in PULSE. Changes during GAP take effect on the next pulse.
- All outputs are registered or decoded from registered state. There is no combinational path from req_i to pulse_o.

## Configuration
- PULSE_SCHED_OVF_EN defined:
  - ovf_o[i] sets when rise[i] occurs while pending[i] is already set and is not being cleared in that cycle.
  - ovf_o is sticky. It clears on reset or when ovf_clr=1; if a set and ovf_clr occur in the same cycle, the set wins.
- PULSE_SCHED_OVF_EN undefined: ovf_clr and ovf_o ports are absent, and merged edges are silently dropped.

## Structure
- pulse_sched_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, PULSE, GAP});
  - default N_CH and GAP_W constants.
- Sub-module pulse_sched_rr: combinational round-robin picker. Inputs are pending and ptr; outputs are a valid flag and the grant index. Implement with a doubled-vector search.

## Test plan
- Reset with req_i=4'b0001 held high → no pulse. Drop req_i[0], then raise it → pulse_o 2 cycles after the sampling edge, pulse_ch_o=0.
- req_i[0..3] all rise together, gap_cfg=0 → pulses on channels 0,1,2,3 at t, t+2, t+4, t+6.
- gap_cfg=3, two channels pending → pulse starts 5 cycles apart; busy_o stays high through GAP.
- en=0 while channels 1 and 2 have edges → pending_o=4'b0110 and no pulse. en=1 → channel 1 then channel 2 (ptr at 0).
- Channel 2 toggles twice before its grant → exactly one pulse. With PULSE_SCHED_OVF_EN, ovf_o[2]=1 until ovf_clr.
- reset asserted during GAP → next cycle busy_o=0, pending_o=0, pulse_ch_o=0.
